differentiator: RTL and testbench

- Streaming first-difference block, the inverse of the running-sum accumulator: out[n] = in[n] - in[n-1] within a frame.
- Recovers per-sample deltas from accumulated, integrated streams in the DSP datapath.
- Sits between an accumulator-fed stage and downstream consumers.
- Ready/valid handshake on both sides; one registered output stage; history cleared at each frame boundary.

---
 rtl/differentiator_if.sv | 25 ++
 rtl/differentiator.sv | 116 +++++++++++
 tb/tb_differentiator.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/differentiator_if.sv
// Stream bundle for the differentiator: sample input side and difference output side.
interface differentiator_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         overflow;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, overflow
  );

  // The differentiator itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, overflow
  );
endinterface

// File: rtl/differentiator.sv
// Streaming first difference out[n] = in[n] - in[n-1], history zeroed at each frame start.
// One registered output stage; define DIFFERENTIATOR_SATURATE_EN to saturate instead of wrapping on overflow.
module differentiator #(
  parameter int W         = 32,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                clear,
  differentiator_if.slave     bus
);

  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic [0:0]       state_q, state_d;
  logic [W-1:0]     prev_q, prev_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             overflow_q, overflow_d;

  logic         in_ready;
  logic         accept;
  logic [W-1:0] prev_sel;
  logic [W:0]   diff_wide;
  logic         diff_ovf;
  logic [W-1:0] diff_res;
  logic         is_last;

  assign in_ready = en & ~clear & (~out_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  // Sample 0 of a frame differences against zero rather than stale history.
  assign prev_sel  = (state_q == ST_RUN) ? prev_q : '0;
  assign diff_wide = {bus.in_data[W-1], bus.in_data} - {prev_sel[W-1], prev_sel};
  assign diff_ovf  = diff_wide[W] ^ diff_wide[W-1];
  assign is_last   = (count_q == LAST_IDX);

  always_comb begin
    diff_res = diff_wide[W-1:0];
`ifdef DIFFERENTIATOR_SATURATE_EN
    if (diff_ovf) begin
      diff_res = diff_wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;

    if (en) begin
      if (clear) begin
        state_d = ST_FIRST;
        prev_d  = '0;
        count_d = '0;
      end else if (accept) begin
        if (is_last) begin
          state_d = ST_FIRST;
          prev_d  = '0;
          count_d = '0;
        end else begin
          state_d = ST_RUN;
          prev_d  = bus.in_data;
          count_d = count_q + 1'b1;
        end
      end

      if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = diff_res;
        out_last_d  = is_last;
        overflow_d  = diff_ovf;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FIRST;
      prev_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_differentiator.sv
// Scoreboard bench for differentiator at W=8, FRAME_LEN=4.
module tb_differentiator;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       ovf;
  } exp_t;

  logic clk;
  logic reset;
  logic en;
  logic clear;
  int   tests_run;
  int   tests_failed;
  exp_t sb[$];
  exp_t mon_item;

  differentiator_if #(.W(8)) bus ();

  differentiator #(.W(8), .FRAME_LEN(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each output transfer (valid & ready & en at the next edge) is checked against the queue head.
  always @(negedge clk) begin
    if (!reset && en && bus.out_valid && bus.out_ready) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_output: got data=%02h with empty scoreboard", bus.out_data);
      end else begin
        mon_item = sb.pop_front();
        tests_run += 2;
        if (bus.out_data !== mon_item.d) begin
          tests_failed++;
          $display("FAIL out_data: got %02h expected %02h", bus.out_data, mon_item.d);
        end
        if (bus.out_last !== mon_item.last) begin
          tests_failed++;
          $display("FAIL out_last: got %0b expected %0b (data %02h)", bus.out_last, mon_item.last, mon_item.d);
        end
        if (bus.overflow !== mon_item.ovf) begin
          tests_failed++;
          $display("FAIL overflow: got %0b expected %0b (data %02h)", bus.overflow, mon_item.ovf, mon_item.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  // Presents one sample until accepted; expected result queued on the accepting cycle.
  task automatic send(input logic [7:0] din, input logic [7:0] exp_d,
                      input logic exp_last, input logic exp_ovf);
    exp_t e;
    bit   done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = din;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.d = exp_d; e.last = exp_last; e.ovf = exp_ovf;
        sb.push_back(e);
        done = 1;
      end
      tick();
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: sample %02h not accepted, in_ready=%0b expected 1", din, bus.in_ready);
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run += 5;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %0b expected 0", bus.out_valid); end
    if (bus.out_data !== 8'h00) begin tests_failed++; $display("FAIL rst_out_data: got %02h expected 00", bus.out_data); end
    if (bus.out_last !== 1'b0) begin tests_failed++; $display("FAIL rst_out_last: got %0b expected 0", bus.out_last); end
    if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL rst_overflow: got %0b expected 0", bus.overflow); end
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready: got %0b expected 1", bus.in_ready); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send(8'd5, 8'd5, 1'b0, 1'b0);
    tests_run += 2;
    if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL latency_valid: got %0b expected 1", bus.out_valid); end
    if (bus.out_data !== 8'd5) begin tests_failed++; $display("FAIL latency_data: got %02h expected 05", bus.out_data); end
    send(8'd12, 8'd7, 1'b0, 1'b0);
    send(8'd10, 8'hFE, 1'b0, 1'b0);
    send(8'd10, 8'd0, 1'b1, 1'b0);
    idle();
    wait_empty();
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_drained: out_valid got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd5, 8'd1, 8'd1, 8'd1};
    for (int i = 0; i < 8; i++) begin
      send(8'(i + 1), exp_tab[i], (i % 4) == 3, 1'b0);
    end
    idle();
    wait_empty();
  endtask

  task automatic test_overflow();
    logic [7:0] pos_exp;
    logic [7:0] neg_exp;
`ifdef DIFFERENTIATOR_SATURATE_EN
    pos_exp = 8'h7F;
    neg_exp = 8'h80;
`else
    pos_exp = 8'hC8;
    neg_exp = 8'h1C;
`endif
    send(8'h9C, 8'h9C, 1'b0, 1'b0);
    send(8'h64, pos_exp, 1'b0, 1'b1);
    send(8'h64, 8'h00, 1'b0, 1'b0);
    send(8'h80, neg_exp, 1'b1, 1'b1);
    idle();
    wait_empty();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send(8'd20, 8'd20, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd25;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run += 4;
      if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready: cycle %0d got %0b expected 0", i, bus.in_ready); end
      if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_out_valid: cycle %0d got %0b expected 1", i, bus.out_valid); end
      if (bus.out_data !== 8'd20) begin tests_failed++; $display("FAIL bp_out_data: cycle %0d got %02h expected 14", i, bus.out_data); end
      if (bus.out_last !== 1'b0) begin tests_failed++; $display("FAIL bp_out_last: cycle %0d got %0b expected 0", i, bus.out_last); end
      tick();
    end
    bus.out_ready = 1'b1;
    send(8'd25, 8'd5, 1'b0, 1'b0);
    tests_run += 2;
    if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_release_valid: got %0b expected 1", bus.out_valid); end
    if (bus.out_data !== 8'd5) begin tests_failed++; $display("FAIL bp_release_data: got %02h expected 05", bus.out_data); end
    send(8'd30, 8'd5, 1'b0, 1'b0);
    send(8'd31, 8'd1, 1'b1, 1'b0);
    idle();
    wait_empty();
  endtask

  task automatic test_clear();
    send(8'd3, 8'd3, 1'b0, 1'b0);
    send(8'd7, 8'd4, 1'b0, 1'b0);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd9;
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL clear_in_ready: got %0b expected 0", bus.in_ready); end
    tick();
    clear = 1'b0;
    send(8'd9, 8'd9, 1'b0, 1'b0);
    send(8'd10, 8'd1, 1'b0, 1'b0);
    send(8'd11, 8'd1, 1'b0, 1'b0);
    send(8'd12, 8'd1, 1'b1, 1'b0);
    idle();
    wait_empty();
  endtask

  task automatic test_enable();
    send(8'd40, 8'd40, 1'b0, 1'b0);
    en           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd45;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run += 3;
      if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL en_in_ready: cycle %0d got %0b expected 0", i, bus.in_ready); end
      if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL en_out_valid: cycle %0d got %0b expected 1", i, bus.out_valid); end
      if (bus.out_data !== 8'd40) begin tests_failed++; $display("FAIL en_out_data: cycle %0d got %02h expected 28", i, bus.out_data); end
      tick();
    end
    en = 1'b1;
    send(8'd45, 8'd5, 1'b0, 1'b0);
    send(8'd46, 8'd1, 1'b0, 1'b0);
    send(8'd47, 8'd1, 1'b1, 1'b0);
    idle();
    wait_empty();
  endtask

  task automatic test_reset_mid();
    send(8'd50, 8'd50, 1'b0, 1'b0);
    send(8'd51, 8'd1, 1'b0, 1'b0);
    idle();
    bus.out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    tests_run += 4;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL arst_out_valid: got %0b expected 0", bus.out_valid); end
    if (bus.out_data !== 8'h00) begin tests_failed++; $display("FAIL arst_out_data: got %02h expected 00", bus.out_data); end
    if (bus.out_last !== 1'b0) begin tests_failed++; $display("FAIL arst_out_last: got %0b expected 0", bus.out_last); end
    if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL arst_overflow: got %0b expected 0", bus.overflow); end
    sb.delete();
    @(negedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    send(8'd6, 8'd6, 1'b0, 1'b0);
    send(8'd7, 8'd1, 1'b0, 1'b0);
    send(8'd8, 8'd1, 1'b0, 1'b0);
    send(8'd9, 8'd1, 1'b1, 1'b0);
    idle();
    wait_empty();
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    en            = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;

    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_clear();
    test_enable();
    test_reset_mid();

    tick();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_empty: %0d outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
